// File: rtl/sd_dac_multi.sv
// Multi-channel second-order sigma-delta DAC with a one-frame holding register.
// Optional LFSR dither into the first integrator when SD_DAC_DITHER_EN is defined.
module sd_dac_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int GUARD    = 4,
  parameter int OSR      = 256
) (
  input  logic                         i_clk,
  input  logic                         i_res,
  input  logic                         i_ce,
  input  logic [CHANNELS*WIDTH-1:0]    i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [CHANNELS-1:0]          o_dac,
  output logic                         o_underrun
);

  localparam int                     A        = WIDTH + GUARD;
  localparam int                     CW       = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0]          CNT_LAST = CW'(OSR - 1);
  localparam logic signed [A-1:0]    FS       = A'(1 << (WIDTH - 1));

  logic [CW-1:0]               r_cnt;
  logic                        r_full;
  logic                        r_ready;
  logic [CHANNELS*WIDTH-1:0]   r_hold;

  logic w_tick;
  logic w_strobe;
  logic w_accept;
  logic w_xfer;
  logic w_full_next;

  assign w_tick   = i_ce;
  assign w_strobe = i_ce & (r_cnt == CNT_LAST);
  assign w_accept = i_valid & r_ready;
  assign w_xfer   = w_strobe & r_full;

  // A strobe that empties the register wins; accept can only land while empty.
  always_comb begin
    w_full_next = r_full;
    if (w_xfer) begin
      w_full_next = 1'b0;
    end else if (w_accept) begin
      w_full_next = 1'b1;
    end
  end

  assign o_ready    = r_ready;
  assign o_underrun = w_strobe & ~r_full;

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= w_strobe ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_hold  <= '0;
    end else begin
      r_full  <= w_full_next;
      r_ready <= ~w_full_next;
      if (w_accept) begin
        r_hold <= i_data;
      end
    end
  end

`ifdef SD_DAC_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_lfsr <= 16'hACE1;
    end else if (w_tick) begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [WIDTH-1:0] r_cur;
      logic signed [A-1:0]     r_acc1;
      logic signed [A-1:0]     r_acc2;
      logic                    r_dac;

      logic signed [A-1:0]     w_x;
      logic signed [A-1:0]     w_fb;
      logic signed [A-1:0]     w_dith;
      logic signed [A-1:0]     w_acc1_next;
      logic signed [A-1:0]     w_acc2_next;

      assign w_x  = {{GUARD{r_cur[WIDTH-1]}}, r_cur};
      assign w_fb = r_dac ? -FS : FS;
`ifdef SD_DAC_DITHER_EN
      assign w_dith = {{(A-1){1'b0}}, r_lfsr[gi]};
`else
      assign w_dith = '0;
`endif
      // Both integrators wrap modulo 2^A; the sum widths are A bits on purpose.
      assign w_acc1_next = r_acc1 + w_x + w_fb + w_dith;
      assign w_acc2_next = r_acc2 + w_acc1_next + w_fb;

      always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
          r_cur  <= '0;
          r_acc1 <= '0;
          r_acc2 <= '0;
          r_dac  <= 1'b0;
        end else begin
          if (w_tick) begin
            r_acc1 <= w_acc1_next;
            r_acc2 <= w_acc2_next;
            r_dac  <= ~w_acc2_next[A-1];
          end
          if (w_xfer) begin
            r_cur <= r_hold[gi*WIDTH +: WIDTH];
          end
        end
      end

      assign o_dac[gi] = r_dac;
    end
  endgenerate

endmodule

// File: tb/tb_sd_dac_multi.sv
// Scoreboard bench for sd_dac_multi: a cycle model queues expectations, a monitor compares.
module tb_sd_dac_multi;

  localparam int W   = 16;
  localparam int CH  = 2;
  localparam int G   = 4;
  localparam int OSR = 4;
  localparam int A   = W + G;
  localparam longint FSV = longint'(1) << (W - 1);
  localparam logic [CH*W-1:0] FS_FRAME = {16'h8000, 16'h7FFF};

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            ce    = 1'b0;
  logic            valid = 1'b0;
  logic [CH*W-1:0] data  = '0;
  logic            ready;
  logic [CH-1:0]   dac;
  logic            und;

  sd_dac_multi #(.WIDTH(W), .CHANNELS(CH), .GUARD(G), .OSR(OSR)) dut (
    .i_clk(clk), .i_res(rst_n), .i_ce(ce), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_dac(dac), .o_underrun(und)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] dac;
    logic          ready;
    logic          und;
    logic          after_tick;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [CH-1:0] hist[$];
  logic          rdy_log[$];
  logic          und_log[$];
  int            n_pass  = 0;
  int            n_total = 0;

  // cycle model state
  int              m_cnt;
  bit              m_full;
  logic [CH*W-1:0] m_hold;
  longint          m_cur[CH];
  longint          m_a1[CH];
  longint          m_a2[CH];
  bit              m_dac[CH];
  bit              m_last_tick;
  logic [15:0]     m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic longint wrap(input longint v);
    longint m;
    m = longint'(1) << A;
    v = v % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  // Hand-derived zero-input sequence: 1,1,0,1,0,0 then 1,1,0,0 repeating.
  function automatic bit undith(input int t);
    bit [5:0] head;
    head = 6'b001011;
    if (t <= 6) return head[t-1];
    return ((t - 7) % 4) < 2;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_full = 0; m_hold = '0; m_last_tick = 0; m_lfsr = 16'hACE1;
    for (int i = 0; i < CH; i++) begin
      m_cur[i] = 0; m_a1[i] = 0; m_a2[i] = 0; m_dac[i] = 0;
    end
  endtask

  task automatic drive(input bit c, input bit v, input logic [CH*W-1:0] d);
    exp_t   e;
    bit     strobe;
    longint fb;
    longint dith;
    bit     lb;
    @(posedge clk); #1;
    ce = c; valid = v; data = d;
    strobe = c && (m_cnt == OSR - 1);
    for (int i = 0; i < CH; i++) e.dac[i] = m_dac[i];
    e.ready      = !m_full;
    e.und        = strobe && !m_full;
    e.after_tick = m_last_tick;
    sb_q.push_back(e);
    if (c) begin
      for (int i = 0; i < CH; i++) begin
        fb   = m_dac[i] ? -FSV : FSV;
        dith = 0;
`ifdef SD_DAC_DITHER_EN
        dith = longint'(m_lfsr[i]);
`endif
        m_a1[i]  = wrap(m_a1[i] + m_cur[i] + fb + dith);
        m_a2[i]  = wrap(m_a2[i] + m_a1[i] + fb);
        m_dac[i] = (m_a2[i] >= 0);
      end
      lb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {lb, m_lfsr[15:1]};
      m_cnt  = strobe ? 0 : m_cnt + 1;
    end
    if (strobe && m_full) begin
      for (int i = 0; i < CH; i++) m_cur[i] = longint'($signed(m_hold[i*W +: W]));
      m_full = 0;
    end else if (v && !m_full) begin
      m_hold = d;
      m_full = 1;
      $display("tb: frame accepted ch0=%h ch1=%h", d[W-1:0], d[2*W-1:W]);
    end
    m_last_tick = c;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("o_dac", 32'(dac), 32'(mon_e.dac));
      check("o_ready", 32'(ready), 32'(mon_e.ready));
      check("o_underrun", 32'(und), 32'(mon_e.und));
      if (mon_e.after_tick) hist.push_back(dac);
      rdy_log.push_back(ready);
      und_log.push_back(und);
    end
  end

  task automatic do_reset(input bit chk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_dac", 32'(dac), 32'h0);
      check("rst_ready", 32'(ready), 32'h1);
      check("rst_underrun", 32'(und), 32'h0);
    end
    ce = 1'b0; valid = 1'b0; data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    hist.delete(); rdy_log.delete(); und_log.delete();
  endtask

  task automatic drain();
    @(negedge clk); #2;
    check("sb_drained", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    int ones0;
    int ones1;
    int diffs;
    model_reset();
    do_reset(1'b1);

    // zero frames, continuous ticks
    for (int k = 1; k <= 4097; k++) drive(1'b1, 1'b1, '0);
    drain();
    check("zero_hist_len", 32'(hist.size() >= 4096), 32'h1);
    ones0 = 0; ones1 = 0; diffs = 0;
    for (int i = 0; i < 4096; i++) begin
      ones0 += int'(hist[i][0]);
      ones1 += int'(hist[i][1]);
      if (hist[i][0] != undith(i + 1)) diffs++;
    end
`ifdef SD_DAC_DITHER_EN
    check($sformatf("dith_density_ch0_%0d", ones0),
          32'((ones0 * 100 >= 4096 * 49) && (ones0 * 100 <= 4096 * 51)), 32'h1);
    check($sformatf("dith_density_ch1_%0d", ones1),
          32'((ones1 * 100 >= 4096 * 49) && (ones1 * 100 <= 4096 * 51)), 32'h1);
    check("dith_differs", 32'(diffs > 0), 32'h1);
`else
    for (int t = 1; t <= 10; t++) begin
      check($sformatf("zero_ch0_t%0d", t), 32'(hist[t-1][0]), 32'(undith(t)));
      check($sformatf("zero_ch1_t%0d", t), 32'(hist[t-1][1]), 32'(undith(t)));
    end
    check($sformatf("density_ch0_%0d", ones0),
          32'((ones0 * 1000 >= 4096 * 498) && (ones0 * 1000 <= 4096 * 502)), 32'h1);
    check($sformatf("density_ch1_%0d", ones1),
          32'((ones1 * 1000 >= 4096 * 498) && (ones1 * 1000 <= 4096 * 502)), 32'h1);
    check("zero_seq_match", 32'(diffs), 32'h0);
`endif

    // mid-run reset with a full holding register
    do_reset(1'b1);

    // full-scale frames, back-to-back offers, then starvation
    for (int k = 1; k <= 95; k++) drive(1'b1, k <= 77, FS_FRAME);
    drain();
    check("hs_ready_c1", 32'(rdy_log[0]), 32'h1);
    for (int k = 2; k <= 4; k++) check($sformatf("hs_ready_c%0d", k), 32'(rdy_log[k-1]), 32'h0);
    check("hs_ready_c5", 32'(rdy_log[4]), 32'h1);
    for (int k = 6; k <= 8; k++) check($sformatf("hs_ready_c%0d", k), 32'(rdy_log[k-1]), 32'h0);
    check("hs_ready_c9", 32'(rdy_log[8]), 32'h1);
    for (int k = 1; k <= 95; k++)
      check($sformatf("underrun_c%0d", k), 32'(und_log[k-1]), 32'(k == 84 || k == 88 || k == 92));
    check("fs_ch0_t5", 32'(hist[4][0]), 32'h0);
    for (int t = 6; t <= 18; t++) check($sformatf("fs_ch0_t%0d", t), 32'(hist[t-1][0]), 32'h1);
    for (int t = 5; t <= 18; t++) check($sformatf("fs_ch1_t%0d", t), 32'(hist[t-1][1]), 32'h0);

    // tick enable toggling must not change the per-tick sequence
    do_reset(1'b0);
    for (int k = 1; k <= 42; k++) drive(k % 2 == 1, 1'b1, '0);
    drain();
    check("toggle_hist_len", 32'(hist.size()), 32'd21);
`ifndef SD_DAC_DITHER_EN
    for (int t = 1; t <= 10; t++)
      check($sformatf("toggle_ch0_t%0d", t), 32'(hist[t-1][0]), 32'(undith(t)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
